// File: rtl/tm1640_pkg.sv
// rtl/tm1640_pkg.sv - TM1640 writer states and protocol constants (TM1640_FIXED_ADDR_EN adds PRE_CMD)
package tm1640_pkg;

    localparam logic [7:0] POS_CMD_ONLY        = 8'hFF;
    localparam logic [7:0] CMD_DATA_FIXED      = 8'h44;
    localparam logic [7:0] CMD_DISPLAY_ON_BASE = 8'h88;

`ifdef TM1640_FIXED_ADDR_EN
    typedef enum logic [2:0] {
        IDLE, PRE_CMD, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI, GAP
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI, GAP
    } state_e;
`endif

endpackage

// File: rtl/tm1640_tick_gen.sv
// rtl/tm1640_tick_gen.sv - CLK_DIV prescaler with sync clear, one-cycle tick on terminal count
module tm1640_tick_gen #(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == 8'(CLK_DIV - 1));
        cnt_d  = cnt_q + 8'd1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tm1640_writer.sv
// rtl/tm1640_writer.sv - TM1640 two-wire writer; TM1640_FIXED_ADDR_EN prepends a 0x44 command frame
module tm1640_writer
    import tm1640_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       valid,
    input  logic [7:0] pos,
    input  logic [7:0] value,
    output logic       busy,
    output logic       DIN,
    output logic       SCLK
);

    state_e      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [3:0]  bit_q, bit_d;
    logic        two_q, two_d;
    logic        din_q, din_d;
    logic        sclk_q, sclk_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic [3:0]  last_bit;
`ifdef TM1640_FIXED_ADDR_EN
    logic        pend_q, pend_d;
    logic [15:0] hold_q, hold_d;
`endif

    // Counter is held at zero in IDLE so every frame starts on a fresh tick.
    tm1640_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    assign last_bit = two_q ? 4'd15 : 4'd7;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            two_q   <= 1'b0;
            din_q   <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef TM1640_FIXED_ADDR_EN
            pend_q  <= 1'b0;
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            two_q   <= two_d;
            din_q   <= din_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
`ifdef TM1640_FIXED_ADDR_EN
            pend_q  <= pend_d;
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        two_d   = two_q;
`ifdef TM1640_FIXED_ADDR_EN
        pend_d  = pend_q;
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid && !busy_q) begin
                    bit_d = '0;
                    if (pos == POS_CMD_ONLY) begin
                        sr_d    = {8'h00, value};
                        two_d   = 1'b0;
                        state_d = START;
                    end else begin
`ifdef TM1640_FIXED_ADDR_EN
                        // Data command goes first; the real request waits in hold.
                        sr_d    = {8'h00, CMD_DATA_FIXED};
                        two_d   = 1'b0;
                        pend_d  = 1'b1;
                        hold_d  = {value, pos};
                        state_d = PRE_CMD;
`else
                        sr_d    = {value, pos};
                        two_d   = 1'b1;
                        state_d = START;
`endif
                    end
                end
            end
`ifdef TM1640_FIXED_ADDR_EN
            PRE_CMD: if (tick) state_d = BIT_LO;
`endif
            START:   if (tick) state_d = BIT_LO;
            BIT_LO:  if (tick) state_d = BIT_HI;
            BIT_HI: begin
                if (tick) begin
                    sr_d    = sr_q >> 1;
                    bit_d   = bit_q + 4'd1;
                    state_d = (bit_q == last_bit) ? STOP_LO : BIT_LO;
                end
            end
            STOP_LO: if (tick) state_d = STOP_HI;
            STOP_HI: if (tick) state_d = GAP;
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
`ifdef TM1640_FIXED_ADDR_EN
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        sr_d    = hold_q;
                        two_d   = 1'b1;
                        bit_d   = '0;
                        state_d = START;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line levels follow the next state so the pins change on the same edge as the state.
    always_comb begin
        din_d  = 1'b1;
        sclk_d = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
`ifdef TM1640_FIXED_ADDR_EN
            PRE_CMD: begin din_d = 1'b0;    sclk_d = 1'b1; end
`endif
            START:   begin din_d = 1'b0;    sclk_d = 1'b1; end
            BIT_LO:  begin din_d = sr_d[0]; sclk_d = 1'b0; end
            BIT_HI:  begin din_d = din_q;   sclk_d = 1'b1; end
            STOP_LO: begin din_d = 1'b0;    sclk_d = 1'b0; end
            STOP_HI: begin din_d = 1'b0;    sclk_d = 1'b1; end
            default: begin din_d = 1'b1;    sclk_d = 1'b1; end
        endcase
    end

    assign busy = busy_q;
    assign DIN  = din_q;
    assign SCLK = sclk_q;

endmodule

// File: tb/tb_tm1640_writer.sv
// tb/tb_tm1640_writer.sv - directed bench for tm1640_writer decoding DIN/SCLK frames
module tb_tm1640_writer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] pos = 8'h00;
    logic [7:0] value = 8'h00;
    logic       busy, DIN, SCLK;

    int tests = 0;
    int fails = 0;

    tm1640_writer #(.CLK_DIV(6)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .valid(valid),
        .pos  (pos),
        .value(value),
        .busy (busy),
        .DIN  (DIN),
        .SCLK (SCLK)
    );

    always #5 CLK = ~CLK;

    // Line decoder: start/stop are DIN edges with SCLK high; the last rise before stop is the stop clock.
    logic        sclk_p = 1'b1, din_p = 1'b1, busy_p = 1'b0;
    logic [31:0] cur_bits = '0;
    int          nrise = 0, starts = 0, stops = 0, busy_cyc = 0, busy_falls = 0, fr_cnt = 0;
    int          fr_n [16];
    logic [31:0] fr_d [16];

    always @(negedge CLK) begin
        if (SCLK && sclk_p && din_p && !DIN) begin
            starts++;
            nrise    = 0;
            cur_bits = '0;
        end else if (SCLK && sclk_p && !din_p && DIN) begin
            stops++;
            fr_n[fr_cnt % 16] = nrise - 1;
            fr_d[fr_cnt % 16] = cur_bits;
            fr_cnt++;
        end
        if (SCLK && !sclk_p) begin
            if (nrise < 32) cur_bits[nrise] = DIN;
            nrise++;
        end
        if (busy) busy_cyc++;
        if (busy_p && !busy) busy_falls++;
        sclk_p = SCLK;
        din_p  = DIN;
        busy_p = busy;
    end

    int b0, s0, f0, bf0, viol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b0  = busy_cyc;
        s0  = starts;
        f0  = fr_cnt;
        bf0 = busy_falls;
    endtask

    task automatic accept(input logic [7:0] p, input logic [7:0] v);
        valid = 1'b1;
        pos   = p;
        value = v;
        @(posedge CLK); #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
        @(negedge CLK); #1;
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge CLK);
        #1;
        check("rst_din", {31'd0, DIN}, 32'd1);
        check("rst_sclk", {31'd0, SCLK}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        RST  = 1'b0;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            if (!(DIN === 1'b1 && SCLK === 1'b1 && busy === 1'b0)) viol++;
        end
        check("idle_50", viol, 0);

        // Command-only byte 0x89
        snap();
        accept(8'hFF, 8'h89);
        wait_idle("cmd89");
        check("cmd89_busy", busy_cyc - b0, 120);
        check("cmd89_frames", fr_cnt - f0, 1);
        check("cmd89_starts", starts - s0, 1);
        check("cmd89_rises", fr_n[f0 % 16], 8);
        check("cmd89_data", fr_d[f0 % 16], 32'h0000_0089);
        check("cmd89_idle_din", {31'd0, DIN}, 32'd1);
        check("cmd89_idle_sclk", {31'd0, SCLK}, 32'd1);

`ifdef TM1640_FIXED_ADDR_EN
        // Address/data with automatic fixed-address command frame
        snap();
        accept(8'hC0, 8'hFF);
        wait_idle("fix");
        check("fix_busy", busy_cyc - b0, 336);
        check("fix_busy_falls", busy_falls - bf0, 1);
        check("fix_frames", fr_cnt - f0, 2);
        check("fix_starts", starts - s0, 2);
        check("fix_cmd_rises", fr_n[f0 % 16], 8);
        check("fix_cmd_data", fr_d[f0 % 16], 32'h0000_0044);
        check("fix_dat_rises", fr_n[(f0 + 1) % 16], 16);
        check("fix_dat_data", fr_d[(f0 + 1) % 16], 32'h0000_FFC0);
`else
        // Address C3 then data A5 in one frame
        snap();
        accept(8'hC3, 8'hA5);
        wait_idle("two");
        check("two_busy", busy_cyc - b0, 216);
        check("two_frames", fr_cnt - f0, 1);
        check("two_starts", starts - s0, 1);
        check("two_rises", fr_n[f0 % 16], 16);
        check("two_data", fr_d[f0 % 16], 32'h0000_A5C3);
`endif

        // valid while busy is ignored; the first busy=0 cycle accepts
        snap();
        accept(8'hFF, 8'h89);
        for (int i = 1; i <= 1000 && busy; i++) begin
            if (i == 40 || i == 100) begin
                valid = 1'b1;
                pos   = 8'h12;
                value = 8'h34;
            end else begin
                valid = 1'b0;
            end
            @(posedge CLK); #1;
        end
        valid = 1'b0;
        check("ign_not_busy", {31'd0, busy}, 32'd0);
        check("ign_busy", busy_cyc - b0, 120);
        check("ign_frames", fr_cnt - f0, 1);
        check("ign_data", fr_d[f0 % 16], 32'h0000_0089);
        snap();
        accept(8'hFF, 8'h3C);
        check("b2b_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle("b2b");
        check("b2b_busy", busy_cyc - b0, 120);
        check("b2b_data", fr_d[f0 % 16], 32'h0000_003C);

        // Reset 70 cycles into a two-byte request
        accept(8'h01, 8'h02);
        repeat (69) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("abort_din", {31'd0, DIN}, 32'd1);
        check("abort_sclk", {31'd0, SCLK}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        snap();
        accept(8'hFF, 8'h5A);
        wait_idle("post");
        check("post_busy", busy_cyc - b0, 120);
        check("post_frames", fr_cnt - f0, 1);
        check("post_data", fr_d[f0 % 16], 32'h0000_005A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
